// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl
//   Captures one record per retired instruction into a small FIFO and
//   presents the oldest record to a trace sink.
//   Parameters:
//     DEPTH         FIFO entries (power of two, 2..64)
//     STALL_ON_FULL 1: back-pressure the core when full, 0: drop and count
//   Ports:
//     clk, reset                  single clock, synchronous active-high reset
//     trace_en                    capture enable (drives OFF/RUN/DRAIN FSM)
//     ret_valid/pc/insn/rd/wdata  retirement record from the core
//     core_stall                  retirement back-pressure (combinational)
//     out_valid/out_ready         head record handshake
//     out_pc/insn/rd/wdata/seq    registered head record fields
//     out_compressed              head insn[1:0] != 2'b11
//     drop_count                  saturating count of discarded records
//     occupancy                   current entry count
//     state_o                     00 OFF, 01 RUN, 10 DRAIN
module trace_buf_ctrl #(
  parameter int DEPTH         = 8,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_insn,
  input  logic [4:0]               ret_rd,
  input  logic [31:0]              ret_wdata,
  output logic                     core_stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_insn,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_wdata,
  output logic                     out_compressed,
  output logic [15:0]              out_seq,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int REC_W = 32 + 32 + 5 + 32 + 16;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic [REC_W-1:0] mem [DEPTH];

  logic [1:0]       state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_succ;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [15:0]      seq_reg;
  logic [15:0]      drop_reg;
  logic [REC_W-1:0] head_reg;
  logic [REC_W-1:0] push_rec;

  logic is_run, is_full, is_empty;
  logic pop_fire, retire, push_fire, drop_fire;
  logic head_from_push, head_from_mem;

  assign is_run   = (state_reg == ST_RUN);
  assign is_full  = (occ_reg == OCC_FULL);
  assign is_empty = (occ_reg == '0);
  assign pop_fire = !is_empty && out_ready;

  generate
    if (STALL_ON_FULL != 0) begin : g_stall
      // A pop in the same cycle frees a slot, so no stall is needed then.
      assign core_stall = is_run && is_full && !pop_fire;
    end else begin : g_nostall
      assign core_stall = 1'b0;
    end
  endgenerate

  // A retirement that is not held off consumes a sequence number whether
  // it is stored or dropped, so gaps in out_seq reveal drops.
  assign retire    = is_run && ret_valid && !core_stall;
  assign push_fire = retire && (!is_full || pop_fire);
  assign drop_fire = retire && is_full && !pop_fire;

  assign push_rec    = {ret_pc, ret_insn, ret_rd, ret_wdata, seq_reg};
  assign rd_ptr_succ = rd_ptr_reg + PTR_W'(1);

  // The head register must track whichever entry becomes the head next
  // cycle: the incoming record when the FIFO is (or is becoming) empty,
  // otherwise the entry after the one being popped.
  assign head_from_push = push_fire && (is_empty || (occ_reg == OCC_ONE && pop_fire));
  assign head_from_mem  = pop_fire && (occ_reg > OCC_ONE);

  always_comb begin
    occ_next = occ_reg;
    case ({push_fire, pop_fire})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:   if (trace_en) state_next = ST_RUN;
      ST_RUN:   if (!trace_en) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (trace_en)      state_next = ST_RUN;
        else if (is_empty) state_next = ST_OFF;
      end
      default:  state_next = ST_OFF;
    endcase
  end

  // Record storage: write-only port plus a registered read into head_reg.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr_reg] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
    end else if (head_from_push) begin
      head_reg <= push_rec;
    end else if (head_from_mem) begin
      head_reg <= mem[rd_ptr_succ];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_OFF;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      seq_reg    <= '0;
      drop_reg   <= '0;
    end else begin
      state_reg <= state_next;
      occ_reg   <= occ_next;
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_succ;
      if (retire)    seq_reg    <= seq_reg + 16'd1;
      if (drop_fire && drop_reg != 16'hFFFF) drop_reg <= drop_reg + 16'd1;
    end
  end

  assign {out_pc, out_insn, out_rd, out_wdata, out_seq} = head_reg;
  assign out_valid      = !is_empty;
  assign out_compressed = (out_insn[1:0] != 2'b11);
  assign occupancy      = occ_reg;
  assign state_o        = state_reg;
  assign drop_count     = drop_reg;

endmodule

// File: tb/tb_trace_buf_ctrl.sv
// Bench for trace_buf_ctrl: a stall-mode and a drop-mode instance share
// the same stimulus; a queue-based model checks both every cycle, and
// directed scenarios pin key values with literals.
module tb_trace_buf_ctrl;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [15:0] seq;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_insn;
  logic [4:0]  ret_rd;
  logic [31:0] ret_wdata;
  logic        out_ready;

  // index 0: STALL_ON_FULL=1, index 1: STALL_ON_FULL=0
  logic        o_stall [2];
  logic        o_valid [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_insn  [2];
  logic [4:0]  o_rd    [2];
  logic [31:0] o_wdata [2];
  logic        o_comp  [2];
  logic [15:0] o_seq   [2];
  logic [15:0] o_drop  [2];
  logic [3:0]  o_occ   [2];
  logic [1:0]  o_state [2];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  rec_t        mq      [2][$];
  int          m_state [2];
  int          m_seq   [2];
  int          m_drops [2];
  logic [15:0] pops    [2][$];

  trace_buf_ctrl #(.DEPTH(DEPTH), .STALL_ON_FULL(1)) dut_s (
    .clk(clk), .reset(reset), .trace_en(trace_en), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_insn(ret_insn), .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .core_stall(o_stall[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_pc(o_pc[0]), .out_insn(o_insn[0]), .out_rd(o_rd[0]), .out_wdata(o_wdata[0]),
    .out_compressed(o_comp[0]), .out_seq(o_seq[0]), .drop_count(o_drop[0]),
    .occupancy(o_occ[0]), .state_o(o_state[0])
  );

  trace_buf_ctrl #(.DEPTH(DEPTH), .STALL_ON_FULL(0)) dut_d (
    .clk(clk), .reset(reset), .trace_en(trace_en), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .ret_insn(ret_insn), .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .core_stall(o_stall[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_pc(o_pc[1]), .out_insn(o_insn[1]), .out_rd(o_rd[1]), .out_wdata(o_wdata[1]),
    .out_compressed(o_comp[1]), .out_seq(o_seq[1]), .drop_count(o_drop[1]),
    .occupancy(o_occ[1]), .state_o(o_state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge process: compare DUTs with the model, log pops, then advance
  // the model using the inputs that the next rising edge will sample.
  initial begin
    int   sz;
    bit   pop, full, stall;
    rec_t r;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        sz = mq[m].size();
        if (cmp_en) begin
          chk($sformatf("m%0d occupancy", m), o_occ[m], sz);
          chk($sformatf("m%0d out_valid", m), o_valid[m], sz != 0);
          chk($sformatf("m%0d state", m), o_state[m], m_state[m]);
          chk($sformatf("m%0d drop_count", m), o_drop[m], m_drops[m]);
          chk($sformatf("m%0d core_stall", m), o_stall[m],
              (m == 0) && m_state[m] == 1 && sz == DEPTH && !out_ready);
          if (sz != 0) begin
            chk($sformatf("m%0d out_pc", m), o_pc[m], mq[m][0].pc);
            chk($sformatf("m%0d out_insn", m), o_insn[m], mq[m][0].insn);
            chk($sformatf("m%0d out_rd", m), o_rd[m], mq[m][0].rd);
            chk($sformatf("m%0d out_wdata", m), o_wdata[m], mq[m][0].wdata);
            chk($sformatf("m%0d out_seq", m), o_seq[m], mq[m][0].seq);
            chk($sformatf("m%0d out_compressed", m), o_comp[m], mq[m][0].insn[1:0] != 2'b11);
          end
          if (o_valid[m] && out_ready) begin
            pops[m].push_back(o_seq[m]);
            $display("pop inst=%0d seq=%0d pc=%h insn=%h", m, o_seq[m], o_pc[m], o_insn[m]);
          end
        end
        if (reset) begin
          mq[m].delete();
          m_state[m] = 0;
          m_seq[m]   = 0;
          m_drops[m] = 0;
        end else begin
          pop   = (sz != 0) && out_ready;
          full  = (sz == DEPTH);
          stall = (m == 0) && m_state[m] == 1 && full && !pop;
          if (pop) void'(mq[m].pop_front());
          if (m_state[m] == 1 && ret_valid && !stall) begin
            r.pc = ret_pc; r.insn = ret_insn; r.rd = ret_rd; r.wdata = ret_wdata;
            r.seq = 16'(m_seq[m]);
            m_seq[m] = (m_seq[m] + 1) % 65536;
            if (!full || pop) mq[m].push_back(r);
            else if (m_drops[m] != 65535) m_drops[m]++;
          end
          case (m_state[m])
            0: if (trace_en) m_state[m] = 1;
            1: if (!trace_en) m_state[m] = 2;
            default: if (trace_en) m_state[m] = 1; else if (sz == 0) m_state[m] = 0;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input int k);
    logic [31:0] kk;
    kk = k;
    ret_valid = 1'b1;
    ret_pc    = 32'h0000_1000 + (kk << 2);
    ret_insn  = kk[0] ? 32'h0000_4501 : {kk[15:0], 16'h0093};
    ret_rd    = kk[4:0];
    ret_wdata = 32'hA5A5_0000 + kk;
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    ret_pc = '0; ret_insn = '0; ret_rd = '0; ret_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("reset out_valid", o_valid[m], 0);
      chk("reset occupancy", o_occ[m], 0);
      chk("reset state", o_state[m], 0);
      chk("reset drop_count", o_drop[m], 0);
      chk("reset core_stall", o_stall[m], 0);
      chk("reset out_pc", o_pc[m], 0);
      chk("reset out_seq", o_seq[m], 0);
    end

    // Single capture
    trace_en = 1'b1;
    tick();
    chk("enable state RUN", o_state[0], 1);
    ret_valid = 1'b1; ret_pc = 32'h8000_0000; ret_insn = 32'h0050_0093;
    ret_rd = 5'd1; ret_wdata = 32'h0000_0005;
    tick();
    ret_valid = 1'b0;
    chk("single out_valid", o_valid[0], 1);
    chk("single out_pc", o_pc[0], 32'h8000_0000);
    chk("single out_rd", o_rd[0], 1);
    chk("single out_seq", o_seq[0], 0);
    chk("single out_compressed", o_comp[0], 0);
    out_ready = 1'b1;
    tick();
    chk("single popped occupancy", o_occ[0], 0);

    // Compressed capture with out_ready already high on an empty FIFO
    ret_valid = 1'b1; ret_pc = 32'h8000_0004; ret_insn = 32'h0000_4501;
    ret_rd = 5'd10; ret_wdata = 32'h0000_0000;
    tick();
    ret_valid = 1'b0;
    chk("compressed out_valid", o_valid[0], 1);
    chk("compressed out_compressed", o_comp[0], 1);
    chk("compressed out_seq", o_seq[0], 1);
    tick();
    out_ready = 1'b0;
    chk("compressed popped occupancy", o_occ[1], 0);

    // Full: stall vs drop
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pops[0].delete(); pops[1].delete();
    for (int k = 0; k < 8; k++) begin
      present(k);
      tick();
    end
    present(8);
    #1;
    chk("full occupancy stall inst", o_occ[0], 8);
    chk("full core_stall stall inst", o_stall[0], 1);
    chk("full core_stall drop inst", o_stall[1], 0);
    tick();
    present(9);
    tick();
    chk("drop_count drop inst", o_drop[1], 2);
    chk("drop_count stall inst", o_drop[0], 0);
    out_ready = 1'b1;
    #1;
    chk("stall released by pop", o_stall[0], 0);
    tick();
    ret_valid = 1'b0;
    chk("push+pop full occupancy", o_occ[0], 8);
    chk("push+pop full head seq", o_seq[0], 1);
    for (int i = 0; i < 20 && (o_occ[0] != 0 || o_occ[1] != 0); i++) tick();
    chk("drain bound stall inst", o_occ[0], 0);
    chk("drain bound drop inst", o_occ[1], 0);
    out_ready = 1'b0;
    chk("stall inst pop count", pops[0].size(), 9);
    chk("drop inst pop count", pops[1].size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < pops[0].size()) chk($sformatf("stall inst pop %0d seq", i), pops[0][i], i);
      if (i < pops[1].size()) chk($sformatf("drop inst pop %0d seq", i), pops[1][i], (i < 8) ? i : 10);
    end

    // Drain
    pops[0].delete(); pops[1].delete();
    for (int k = 20; k < 23; k++) begin
      present(k);
      tick();
    end
    ret_valid = 1'b0;
    trace_en = 1'b0;
    tick();
    chk("drain state", o_state[0], 2);
    ret_valid = 1'b1; ret_pc = 32'hDEAD_0000;
    tick();
    ret_valid = 1'b0;
    chk("drain ignores ret_valid", o_occ[0], 3);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("drain emptied", o_occ[0], 0);
    chk("drain state while last pops", o_state[0], 2);
    tick();
    out_ready = 1'b0;
    chk("drain to OFF", o_state[0], 0);
    chk("drain delivered", pops[0].size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < pops[0].size()) chk($sformatf("drain stall seq %0d", i), pops[0][i], 9 + i);
      if (i < pops[1].size()) chk($sformatf("drain drop seq %0d", i), pops[1][i], 11 + i);
    end

    // Mid-operation reset with 5 entries buffered
    trace_en = 1'b1;
    tick();
    for (int k = 30; k < 35; k++) begin
      present(k);
      tick();
    end
    ret_valid = 1'b0;
    chk("pre-reset occupancy", o_occ[0], 5);
    chk("pre-reset drop_count", o_drop[1], 2);
    reset = 1'b1; ret_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("mid reset occupancy", o_occ[m], 0);
      chk("mid reset out_valid", o_valid[m], 0);
      chk("mid reset drop_count", o_drop[m], 0);
      chk("mid reset state", o_state[m], 0);
      chk("mid reset out_pc", o_pc[m], 0);
    end
    tick();
    chk("post reset RUN", o_state[0], 1);
    trace_en = 1'b0;
    tick(); tick();
    chk("final OFF", o_state[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
